// File: rtl/decode_execute_pipe.sv
// Two-stage (decode, execute) ALU pipeline with valid/ready handshakes on both sides.
// Build macro DAE_SATURATE_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module decode_execute_pipe #(
    parameter  int WIDTH = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf
);

    localparam int MSB = WIDTH - 1;

    // Bit positions of the one-hot decoded op held in stage 1.
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_ROTL = 6;
    localparam int OP_SLT  = 7;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_rs;
    logic [WIDTH-1:0] s1_rt;
    logic [7:0]       s1_dec;

    logic             s2_free;
    logic             accept;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] exe_rd;
    logic             exe_carry;
    logic             exe_ovf;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // Stage 2 can take new data when it is empty or its result is being consumed; stage 1
    // can take new data when it is empty or moving into stage 2. in_ready is combinational
    // so a drain and an accept can share one cycle without a bubble.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    // Stage 1: capture operands and decode the op select to one-hot.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_rs    <= '0;
            s1_rt    <= '0;
            s1_dec   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_rs  <= rs;
                s1_rt  <= rt;
                s1_dec <= 8'd1 << sel;
            end
        end
    end

    // Execute: combinational datapath between the two register stages.
    always_comb begin
        add_full  = {1'b0, s1_rs} + {1'b0, s1_rt};
        sub_full  = {1'b0, s1_rs} - {1'b0, s1_rt};
        exe_rd    = '0;
        exe_carry = 1'b0;
        exe_ovf   = 1'b0;
        if (s1_dec[OP_ADD]) begin
            exe_rd    = add_full[MSB:0];
            exe_carry = add_full[WIDTH];
            exe_ovf   = (s1_rs[MSB] == s1_rt[MSB]) && (add_full[MSB] != s1_rs[MSB]);
        end else if (s1_dec[OP_SUB]) begin
            exe_rd    = sub_full[MSB:0];
            exe_carry = sub_full[WIDTH];
            exe_ovf   = (s1_rs[MSB] != s1_rt[MSB]) && (sub_full[MSB] != s1_rs[MSB]);
        end else if (s1_dec[OP_AND]) begin
            exe_rd = s1_rs & s1_rt;
        end else if (s1_dec[OP_OR]) begin
            exe_rd = s1_rs | s1_rt;
        end else if (s1_dec[OP_XOR]) begin
            exe_rd = s1_rs ^ s1_rt;
        end else if (s1_dec[OP_SHL]) begin
            exe_rd = s1_rs << s1_rt[SHW-1:0];
        end else if (s1_dec[OP_ROTL]) begin
            exe_rd = {s1_rs[MSB-1:0], s1_rs[MSB]};
        end else if (s1_dec[OP_SLT]) begin
            exe_rd = {{(WIDTH-1){1'b0}}, ($signed(s1_rs) < $signed(s1_rt))};
        end
`ifdef DAE_SATURATE_EN
        // Overflow direction follows the sign of rs for both ADD and SUB.
        if (exe_ovf) begin
            exe_rd = s1_rs[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage 2: result register, held bit-stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            rd         <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                rd         <= exe_rd;
                flag_zero  <= (exe_rd == '0);
                flag_carry <= exe_carry;
                flag_ovf   <= exe_ovf;
            end
        end
    end

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Randomized and directed bench for decode_execute_pipe against an arithmetic reference model.
// Honours DAE_SATURATE_EN when defined for the build.
module tb_decode_execute_pipe;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rd;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;

    always #5 clk = ~clk;

    decode_execute_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs         (rs),
        .rt         (rt),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd         (rd),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit strict_lat   = 1'b0;
    bit rand_done    = 1'b0;

    logic [W+2:0] exp_q[$];
    int           stamp_q[$];
    logic         prev_stall = 1'b0;
    logic [W+2:0] prev_obs;
    logic [W+2:0] obs;

    assign obs = {rd, flag_zero, flag_carry, flag_ovf};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+2:0] pack(input int r, input bit c, input bit o);
        logic [W-1:0] rv;
        rv = r[W-1:0];
        return {rv, (rv == '0), c, o};
    endfunction

    // Reference model: integer arithmetic straight from the op definitions.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] s);
        int ai, bi, sa, sb, ss, r, smax, smin;
        bit c, o;
        ai   = int'(a);
        bi   = int'(b);
        sa   = (ai >= M / 2) ? ai - M : ai;
        sb   = (bi >= M / 2) ? bi - M : bi;
        smax = M / 2 - 1;
        smin = -(M / 2);
        c    = 1'b0;
        o    = 1'b0;
        r    = 0;
        ss   = 0;
        case (s)
            3'd0: begin r = (ai + bi) % M; c = (ai + bi) >= M; ss = sa + sb; end
            3'd1: begin r = (ai - bi + M) % M; c = ai < bi; ss = sa - sb; end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: r = (ai << (bi % W)) % M;
            3'd6: r = ((ai * 2) % M) + (ai / (M / 2));
            default: r = (sa < sb) ? 1 : 0;
        endcase
        if (s == 3'd0 || s == 3'd1) begin
            o = (ss > smax) || (ss < smin);
`ifdef DAE_SATURATE_EN
            if (o) r = (ss > smax) ? smax : M / 2;
`endif
        end
        return pack(r, c, o);
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: observes results and acceptances away from the active edge.
    always @(negedge clk) begin
        logic [W+2:0] e;
        int st;
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", obs, prev_obs);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", obs, 0);
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    st = stamp_q.pop_front();
                    check("result", obs, e);
                    if (strict_lat) check("latency", cyc - st, 2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(rs, rt, sel));
                stamp_q.push_back(cyc);
            end
        end
    end

    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        int t;
        rs       = a;
        rt       = b;
        sel      = s;
        in_valid = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Isolated op on an empty pipe: absent after one edge, present after two.
    task automatic direct_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] s, input logic [W+2:0] want);
        out_ready  = 1'b1;
        strict_lat = 1'b1;
        send_op(a, b, s);
        @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check(tag, obs, want);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic [2:0]   s;

        // Reset held two edges with a live op on the input.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rs        = W'($urandom_range(0, M - 1));
        rt        = W'($urandom_range(0, M - 1));
        sel       = 3'($urandom_range(0, 7));
        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_outputs", obs, 0);
        end
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_no_output", out_valid, 0);
        @(posedge clk);
        #1;

        // Arithmetic and logic directed cases.
        direct_op("add_7_9", 4'd7, 4'd9, 3'd0, pack(0, 1, 0));
`ifdef DAE_SATURATE_EN
        direct_op("add_7_1", 4'd7, 4'd1, 3'd0, pack(7, 0, 1));
        direct_op("sub_8_1", 4'd8, 4'd1, 3'd1, pack(8, 0, 1));
`else
        direct_op("add_7_1", 4'd7, 4'd1, 3'd0, pack(8, 0, 1));
        direct_op("sub_8_1", 4'd8, 4'd1, 3'd1, pack(7, 0, 1));
`endif
        direct_op("sub_3_5", 4'd3, 4'd5, 3'd1, pack(14, 1, 0));
        direct_op("and",  4'b1011, 4'b0110, 3'd2, pack(4'b0010, 0, 0));
        direct_op("or",   4'b1011, 4'b0110, 3'd3, pack(4'b1111, 0, 0));
        direct_op("xor",  4'b1011, 4'b0110, 3'd4, pack(4'b1101, 0, 0));
        direct_op("shl",  4'b1011, 4'b0110, 3'd5, pack(4'b1100, 0, 0));
        direct_op("rotl", 4'b1011, 4'b0110, 3'd6, pack(4'b0111, 0, 0));
        direct_op("slt",  4'b1011, 4'b0110, 3'd7, pack(1, 0, 0));
        drain();

        // Back-to-back sweep, one op per cycle.
        strict_lat = 1'b1;
        a = W'($urandom_range(0, M - 1));
        b = W'($urandom_range(0, M - 1));
        s = 3'($urandom_range(0, 7));
        for (int i = 0; i < 30; i++) begin
            send_op(a, b, s);
            a = a + 1'b1;
            b = b + 2'd2;
            s = s + 1'b1;
        end
        drain();
        strict_lat = 1'b0;

        // Backpressure: two accepts fill the pipe, third op must wait.
        out_ready = 1'b0;
        send_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        send_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        a = W'($urandom);
        b = W'($urandom);
        s = 3'($urandom_range(0, 7));
        rs = a;
        rt = b;
        sel = s;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_op(a, b, s);
        send_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        drain();

        // Reset with both stages holding ops: those results must never appear.
        out_ready = 1'b0;
        send_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        send_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        @(negedge clk);
        check("mid_full", in_ready, 0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_after_valid", out_valid, 0);
        check("mid_after_ready", in_ready, 1);
        @(posedge clk);
        #1;
        idle(5);
        drain();

        // Random traffic with random gaps and random consumer stalls.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    idle($urandom_range(0, 2));
                    send_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_execute_pipe.md
Name: decode_execute_pipe

Overview:
- Parametrised, pipelined successor to the combinational decode-and-execute unit: takes two WIDTH-bit operands (rs, rt) plus a 3-bit op select and produces result rd with status flags.
- Two registered stages (decode, execute) with valid/ready handshakes on both sides; sustains one op per cycle and stalls cleanly under backpressure.
- Sits between an operand source (register-read stage or bench) and a writeback consumer.

Parameters:
- WIDTH, 4, operand/result width in bits; power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width taken from rt[SHW-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  rs/rt/sel valid this cycle
- in_ready  output  1  block can accept an op this cycle
- rs  input  WIDTH  operand A
- rt  input  WIDTH  operand B
- sel  input  3  op select
- out_valid  output  1  rd and flags valid
- out_ready  input  1  consumer accepts the result this cycle
- rd  output  WIDTH  result
- flag_zero  output  1  rd == 0
- flag_carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops
- flag_ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset (rst=1 at posedge): both stage valids cleared; rd, flags = 0; out_valid = 0. in_ready = 1 in the cycle after reset. Reset overrides any handshake in the same cycle and discards in-flight ops.
- Accept when in_valid && in_ready at posedge. Stage 1 registers rs, rt and a one-hot decode of sel. Stage 2 registers the computed rd and flags.
- Latency: accepted at edge k -> out_valid high after edge k+1 (2 register stages). Throughput 1 op/cycle when out_ready = 1.
- Handshake: s2_free = !out_valid || out_ready; s1 advances when s1_valid && s2_free; in_ready = !s1_valid || s2_free (combinational). Stalled stages hold contents bit-stable. out_valid stays high with stable rd/flags until out_ready. No loss, no duplication; results emerge in acceptance order.
- Ops (sel):
  - 000 ADD rs+rt mod 2^WIDTH
  - 001 SUB rs-rt mod 2^WIDTH; carry = borrow (rs<rt unsigned)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL logical: rs << rt[SHW-1:0]
  - 110 ROTL: rs rotated left by 1
  - 111 SLT: rd = 1 if $signed(rs) < $signed(rt), else 0
- flag_ovf: ADD when operands share a sign and the result sign differs; SUB when operand signs differ and the result sign differs from rs.
- flag_zero is computed on the final rd, after saturation when that feature is compiled in.
- Buffer full (both stages valid, out_ready=0) -> in_ready=0. Simultaneous drain and accept in the same cycle is legal, with no bubble.

Optional Feature:
- Macro DAE_SATURATE_EN.
- Defined: ADD/SUB saturate on signed overflow: positive overflow -> 0111..1, negative overflow -> 1000..0. flag_ovf still reports the overflow. flag_carry unchanged.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, rd=0, all flags 0; in_ready=1 after release.
- Arithmetic (WIDTH=4): ADD 7+9 -> rd=0, carry=1, zero=1, ovf=0. ADD 7+1 -> rd=8, ovf=1, carry=0. SUB 3-5 -> rd=4'hE, carry=1, ovf=0. Each appears exactly 2 edges after acceptance.
- Logic/shift: sel=010..111 with rs=4'b1011, rt=4'b0110 -> AND 0010, OR 1111, XOR 1101, SHL (shift 2) 1100, ROTL 0111, SLT 1 (-5<6).
- Sweep: 30 back-to-back ops, rs+=1, rt+=2, sel+=1 per cycle, out_ready=1 -> 30 results in order, one per cycle, each matching the golden model.
- Backpressure: stream 4 ops with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts; rd held stable; on release all 4 results arrive in order, none lost.
- Reset mid-operation: rst while both stages valid -> next cycle out_valid=0 and in-flight results never appear. With DAE_SATURATE_EN: ADD 7+1 -> rd=7, ovf=1; SUB 8-1 -> rd=8, ovf=1.
